// File: rtl/dreg_arbiter.sv
// -----------------------------------------------------------------------------
// dreg_arbiter
//
// Round-robin arbiter feeding a single-entry output register. Up to M
// requesters offer N-bit payloads; one winner per cycle is moved into the
// output register, which is drained by a downstream valid/ready consumer.
//
// Handshake rule, both sides: a beat moves on a rising edge where valid and
// ready are both 1. A producer must hold valid and its payload stable until
// that happens. req_ready is a combinational function of the current state,
// out_ready and req_valid, and is never 1 for a requester whose valid is 0.
//
// Optional feature: define DREG_ARBITER_LOCK_EN to add req_lock and the
// lock_active register, which lets the last grantee keep the output for
// back-to-back transfers while it holds its lock bit.
//
// Ports:
//   clock       rising-edge clock
//   rst_n       asynchronous active-low reset
//   req_valid   [M-1:0] per-requester request
//   req_data    [0:M-1] per-requester N-bit payload
//   req_lock    [M-1:0] per-requester lock request (DREG_ARBITER_LOCK_EN only)
//   req_ready   [M-1:0] one-hot acceptance (combinational)
//   out_valid   output register holds a beat
//   out_ready   downstream consumes the beat
//   out_data    [N-1:0] payload of the held beat
//   out_id      [clog2(M)-1:0] requester that sourced the held beat
//   dbg_state   FSM state (0 = EMPTY, 1 = FULL)
//   dbg_rr_ptr  current round-robin search start
// -----------------------------------------------------------------------------
module dreg_arbiter #(
  parameter int N = 2,
  parameter int M = 2
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [M-1:0]          req_valid,
  input  logic [N-1:0]          req_data [0:M-1],
`ifdef DREG_ARBITER_LOCK_EN
  input  logic [M-1:0]          req_lock,
`endif
  output logic [M-1:0]          req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          out_data,
  output logic [$clog2(M)-1:0]  out_id,
  output logic                  dbg_state,
  output logic [$clog2(M)-1:0]  dbg_rr_ptr
);

  localparam int ID_W = $clog2(M);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    out_data_q, out_data_d;
  logic [ID_W-1:0] out_id_q, out_id_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  logic            accept_en;
  logic            rr_found;
  logic [ID_W-1:0] rr_win;
  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic            xfer;
  logic            use_lock;
  int              idx;

`ifdef DREG_ARBITER_LOCK_EN
  logic            lock_active_q, lock_active_d;
  assign use_lock = lock_active_q;
`else
  assign use_lock = 1'b0;
`endif

  always_comb begin
    accept_en = (state_q == EMPTY) || out_ready;

    // First set request at or after rr_ptr, wrapping past M-1 to 0.
    rr_found = 1'b0;
    rr_win   = '0;
    idx      = 0;
    for (int i = 0; i < M; i++) begin
      idx = (int'(rr_ptr_q) + i) % M;
      if (!rr_found && req_valid[idx]) begin
        rr_found = 1'b1;
        rr_win   = ID_W'(idx);
      end
    end

    // While locked, only the last grantee (still held in out_id) may win.
    // If it has dropped its request, nobody is granted this cycle and the
    // lock is released below.
    if (use_lock) begin
      win_found = req_valid[out_id_q];
      win_id    = out_id_q;
    end else begin
      win_found = rr_found;
      win_id    = rr_win;
    end

    req_ready = '0;
    if (rst_n && accept_en && win_found) begin
      req_ready[win_id] = 1'b1;
    end

    xfer = |(req_valid & req_ready);

    state_d    = state_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    rr_ptr_d   = rr_ptr_q;

    if (xfer) begin
      // Covers EMPTY->FULL and the drain-and-refill case in FULL.
      state_d    = FULL;
      out_data_d = req_data[win_id];
      out_id_d   = win_id;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end

    // The pointer is frozen for as long as a lock was active at the edge.
    if (xfer && !use_lock) begin
      rr_ptr_d = (win_id == ID_W'(M - 1)) ? '0 : win_id + 1'b1;
    end
  end

`ifdef DREG_ARBITER_LOCK_EN
  always_comb begin
    lock_active_d = lock_active_q;
    if (accept_en && lock_active_q && !req_valid[out_id_q]) begin
      lock_active_d = 1'b0;
    end
    if (xfer) begin
      lock_active_d = req_lock[win_id];
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      lock_active_q <= 1'b0;
    end else begin
      lock_active_q <= lock_active_d;
    end
  end
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_id_q   <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign out_valid  = (state_q == FULL);
  assign out_data   = out_data_q;
  assign out_id     = out_id_q;
  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_dreg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dreg_arbiter
//
// Directed bench for dreg_arbiter with M=4, N=2. Every accepted request pushes
// its expected {id, data} into exp_q at the moment the stimulus is driven; a
// monitor pops and compares whenever the output register is drained.
// Combinational and register values are checked at the falling edge, inputs
// are driven 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_dreg_arbiter;

  localparam int N    = 2;
  localparam int M    = 4;
  localparam int ID_W = 2;
  localparam int W    = ID_W + N;

  logic            clock = 1'b0;
  logic            rst_n;
  logic [M-1:0]    req_valid;
  logic [N-1:0]    req_data [0:M-1];
  logic [M-1:0]    req_ready;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_data;
  logic [ID_W-1:0] out_id;
  logic            dbg_state;
  logic [ID_W-1:0] dbg_rr_ptr;
`ifdef DREG_ARBITER_LOCK_EN
  logic [M-1:0]    req_lock;
`endif

  logic [W-1:0]    exp_q[$];
  int              checks = 0;
  int              errors = 0;

  // ---------------------------------------------------------------- clock
  always #5 clock = ~clock;

  dreg_arbiter #(.N(N), .M(M)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
`ifdef DREG_ARBITER_LOCK_EN
    .req_lock   (req_lock),
`endif
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------------------------------------------------------- helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int id);
    exp_q.push_back({ID_W'(id), req_data[id]});
  endtask

  task automatic randomize_data();
    for (int i = 0; i < M; i++) req_data[i] = N'($urandom_range(0, 3));
  endtask

  // ---------------------------------------------------------------- scoreboard
  always @(negedge clock) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("beat_id_data", 32'({out_id, out_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int lock_ids[5];
    int rot_ids[4];
    lock_ids = '{1, 1, 1, 1, 2};
    rot_ids  = '{1, 2, 3, 0};

    rst_n     = 1'b0;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < M; i++) req_data[i] = N'(i);
`ifdef DREG_ARBITER_LOCK_EN
    req_lock  = '0;
`endif

    // Reset state, with requests already pending.
    #12;
    check("rst_req_ready", 32'(req_ready),  0);
    check("rst_out_valid", 32'(out_valid),  0);
    check("rst_out_id",    32'(out_id),     0);
    check("rst_out_data",  32'(out_data),   0);
    check("rst_rr_ptr",    32'(dbg_rr_ptr), 0);
    check("rst_state",     32'(dbg_state),  0);
    req_valid = '0;
    @(negedge clock);
    rst_n = 1'b1;

    // All requesting, downstream always ready: 0,1,2,3,0,1,2,3 at 1 beat/cycle.
    randomize_data();
    tick();
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      push(k % 4);
      @(negedge clock);
      check("rot_req_ready", 32'(req_ready), 32'(1 << (k % 4)));
      if (k > 0) check("rot_throughput", 32'(out_valid), 1);
      tick();
    end
    req_valid = '0;
    @(negedge clock);
    check("rot_last_valid", 32'(out_valid), 1);
    tick();
    @(negedge clock);
    check("rot_drained", 32'(out_valid), 0);
    check("rot_rr_wrap", 32'(dbg_rr_ptr), 0);
    tick();

    // Backpressure: 0101 with out_ready=0 holds beat 0, then 2, then 0.
    randomize_data();
    req_valid = 4'b0101;
    out_ready = 1'b0;
    push(0);
    @(negedge clock);
    check("bp_first_ready", 32'(req_ready), 32'b0001);
    tick();
    @(negedge clock);
    check("bp_full",        32'(out_valid), 1);
    check("bp_ready_zero",  32'(req_ready), 0);
    check("bp_out_id",      32'(out_id),    0);
    req_data[0] = ~req_data[0];   // held beat must keep its captured payload
    tick();
    @(negedge clock);
    check("bp_hold_id",     32'(out_id),    0);
    check("bp_hold_state",  32'(dbg_state), 1);
    check("bp_hold_ready",  32'(req_ready), 0);
    tick();
    out_ready = 1'b1;
    push(2);
    @(negedge clock);
    check("bp_next_ready",  32'(req_ready), 32'b0100);
    tick();
    push(0);
    @(negedge clock);
    check("bp_wrap_ready",  32'(req_ready), 32'b0001);
    check("bp_id2",         32'(out_id),    2);
    tick();
    req_valid = '0;
    @(negedge clock);
    check("bp_id0",         32'(out_id),    0);
    tick();

    // Wrap search: rr_ptr=3, only requester 1 asks with data 2'b10.
    req_valid = 4'b0100;
    push(2);
    @(negedge clock);
    check("wr_setup_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid   = 4'b0010;
    req_data[1] = 2'b10;
    push(1);
    @(negedge clock);
    check("wr_rr_ptr3",     32'(dbg_rr_ptr), 3);
    check("wr_req_ready",   32'(req_ready),  32'b0010);
    tick();
    req_valid = '0;
    @(negedge clock);
    check("wr_out_valid",   32'(out_valid),  1);
    check("wr_out_data",    32'(out_data),   32'b10);
    check("wr_out_id",      32'(out_id),     1);
    check("wr_rr_ptr2",     32'(dbg_rr_ptr), 2);
    tick();

    // Asynchronous reset while FULL, between edges.
    randomize_data();
    req_valid = 4'b1111;
    out_ready = 1'b0;
    push(2);
    @(negedge clock);
    check("ar_ready",       32'(req_ready), 32'b0100);
    tick();
    #2;
    check("ar_pre_full",    32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("ar_out_valid",   32'(out_valid),  0);
    check("ar_out_id",      32'(out_id),     0);
    check("ar_out_data",    32'(out_data),   0);
    check("ar_rr_ptr",      32'(dbg_rr_ptr), 0);
    check("ar_req_ready",   32'(req_ready),  0);
    exp_q.delete();               // held beat is discarded by reset
    req_valid = '0;
    @(negedge clock);
    rst_n = 1'b1;
    tick();
    req_valid = 4'b1111;
    out_ready = 1'b1;
    push(0);
    @(negedge clock);
    check("ar_first_ready", 32'(req_ready), 32'b0001);
    tick();

`ifdef DREG_ARBITER_LOCK_EN
    // Requester 1 locks for three transfers, then releases: 1,1,1,1,2.
    req_lock = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) req_lock = '0;
      push(lock_ids[k]);
      @(negedge clock);
      check("lock_req_ready", 32'(req_ready), 32'(1 << lock_ids[k]));
      tick();
    end
`else
    // Same traffic without locking: plain rotation 1,2,3,0.
    for (int k = 0; k < 4; k++) begin
      push(rot_ids[k]);
      @(negedge clock);
      check("rr_req_ready", 32'(req_ready), 32'(1 << rot_ids[k]));
      tick();
    end
`endif
    req_valid = '0;
    @(negedge clock);
    tick();
    @(negedge clock);
    check("end_empty",      32'(out_valid), 0);
    check("end_queue",      32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dreg_arbiter.md
DREG_ARBITER -- requirements
Module: dreg_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 2, meaning the data width in bits per requester.
REQ-002 The block SHALL have parameter M, default 2, meaning the number of requesters (legal range 2..16).
REQ-003 The block SHALL have clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have req_valid  input  M  per-requester request, bit i belongs to requester i.
REQ-006 The block SHALL have req_data  input  unpacked array [0:M-1] of N-bit packed entries  per-requester payload.
REQ-007 The block SHALL have req_ready  output  M  one-hot acceptance, combinational.
REQ-008 The block SHALL have out_valid  output  1  output register holds a beat.
REQ-009 The block SHALL have out_ready  input  1  downstream consumes the beat.
REQ-010 The block SHALL have out_data  output  N  payload of the held beat.
REQ-011 The block SHALL have out_id  output  clog2(M)  index of the requester that sourced the beat.

Function
REQ-012 The block SHALL contain a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 The block SHALL define accept_en = EMPTY or (FULL and out_ready).
REQ-014 When accept_en and any req_valid bit is set, the block SHALL select winner g as the first set bit at or after rr_ptr, searching upward and wrapping from M-1 to 0.
REQ-015 The block SHALL assert req_ready[g] only in a cycle where accept_en holds and g wins, and SHALL keep all other bits at 0.
REQ-016 On a transfer (req_valid[g] and req_ready[g]), the block SHALL load out_data=req_data[g] and out_id=g at the next edge, and SHALL enter FULL.
REQ-017 After a transfer, the block SHALL set rr_ptr to g+1 modulo M, so g=M-1 wraps rr_ptr to 0.
REQ-018 In FULL with out_ready=1 and no request, the block SHALL go to EMPTY. In FULL with out_ready=0, it SHALL hold out_data, out_id and state unchanged.
REQ-019 For simultaneous drain and new accept in FULL, the block SHALL stay FULL with the new beat, giving 1 beat/cycle throughput.
REQ-020 Latency from transfer to out_valid SHALL be exactly 1 cycle.
REQ-021 In EMPTY, the block SHALL leave out_data and out_id unchanged.
REQ-022 With no req_valid bit set, the block SHALL leave rr_ptr unchanged.

Reset
REQ-023 On rst_n low, the block SHALL immediately force state=EMPTY, out_valid=0, out_data=0, out_id=0, rr_ptr=0 and lock_active=0, without waiting for a clock edge.
REQ-024 A reset mid-operation SHALL discard any held beat; the first accept after release SHALL start its search at requester 0.
REQ-025 While rst_n is low, req_ready SHALL be all-zero.

Configuration
REQ-026 When macro DREG_ARBITER_LOCK_EN is defined, the block SHALL add input port req_lock (width M) and register lock_active.
REQ-027 With DREG_ARBITER_LOCK_EN defined, lock_active SHALL be set when a transfer from g has req_lock[g]=1. It SHALL be cleared when a transfer from g has req_lock[g]=0, or when req_valid[g]=0 during accept_en.
REQ-028 With DREG_ARBITER_LOCK_EN defined and lock_active=1, the winner SHALL be the last grantee regardless of rr_ptr, and rr_ptr SHALL not advance until lock_active clears.
REQ-029 Without DREG_ARBITER_LOCK_EN, the block SHALL have no req_lock port, no lock_active register, and pure round-robin per REQ-014.

Verification
REQ-030 Bench: M=4, req_valid=1111 held, out_ready=1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3 and one beat per cycle.
REQ-031 Bench: req_valid=0101, out_ready=0 -> first beat id 0 held in FULL with req_ready=0000; then out_ready=1 -> next id 2, then 0.
REQ-032 Bench: rr_ptr=3, only req_valid[1]=1 with req_data[1]=2'b10 -> req_ready=0010, next cycle out_data=2'b10, out_id=1, rr_ptr=2.
REQ-033 Bench: rst_n low asynchronously mid-FULL between edges -> out_valid=0 immediately; after release with req_valid=1111 -> first out_id=0.
REQ-034 Bench, DREG_ARBITER_LOCK_EN defined: requester 1 holds req_lock[1]=1 with req_valid=1111 for 3 transfers -> ids 1,1,1; then req_lock[1]=0 -> next ids 1,2.
REQ-035 Bench, DREG_ARBITER_LOCK_EN undefined: same stimulus as REQ-034 minus req_lock -> ids rotate 1,2,3,0.
